// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// master = controller side, slave = datapath side.
interface mc_control_fsm_if #(
    parameter int STATE_W = 6
);
    logic [5:0]         Op;
    logic               Break;
    logic               PCWriteCond;
    logic               BranchNE;
    logic               PCWrite;
    logic               IorD;
    logic               MemWrite;
    logic               IRWrite;
    logic               ALUSrcA;
    logic               RegWrite;
    logic               RegDst;
    logic               AWrite;
    logic               BWrite;
    logic               ALUOutLoad;
    logic [1:0]         MemtoReg;
    logic [1:0]         PCSource;
    logic [2:0]         ALUOp;
    logic [1:0]         ALUSrcB;
    logic [STATE_W-1:0] State_out;
    logic               IllegalOp;

    modport master (
        input  Op, Break,
        output PCWriteCond, BranchNE, PCWrite, IorD, MemWrite, IRWrite,
        output ALUSrcA, RegWrite, RegDst, AWrite, BWrite, ALUOutLoad,
        output MemtoReg, PCSource, ALUOp, ALUSrcB, State_out, IllegalOp
    );

    modport slave (
        output Op, Break,
        input  PCWriteCond, BranchNE, PCWrite, IorD, MemWrite, IRWrite,
        input  ALUSrcA, RegWrite, RegDst, AWrite, BWrite, ALUOutLoad,
        input  MemtoReg, PCSource, ALUOp, ALUSrcB, State_out, IllegalOp
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with one shared memory wait counter.
// Define UC_ILLEGAL_OP_EN to trap unrecognised opcodes in a sticky ILLEGAL state.
module mc_control_fsm #(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    mc_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        F_WAIT   = 4'd1,
        IR_LD    = 4'd2,
        DECODE   = 4'd3,
        RTYPE    = 4'd4,
        RT_WB    = 4'd5,
        BRANCH   = 4'd6,
        MEM_ADDR = 4'd7,
        LW_WAIT  = 4'd8,
        LW_WB    = 4'd9,
        SW_WR    = 4'd10,
        SW_WAIT  = 4'd11,
        LUI      = 4'd12,
        J        = 4'd13,
        BREAK    = 4'd14,
        ILLEGAL  = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write_cond;
        logic       branch_ne;
        logic       pc_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       a_write;
        logic       b_write;
        logic       alu_out_load;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic [1:0] alu_src_b;
    } ctl_t;

    localparam logic [3:0] MW = 4'(MEM_WAIT);

    state_t     state;
    state_t     nxt;
    logic [3:0] wcnt;
    logic [3:0] nxt_wcnt;
    ctl_t       ctl;
    logic       op_bne;

    function automatic ctl_t dec(input state_t s, input logic ne);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_b    = 2'b01;
                c.alu_out_load = 1'b1;
            end
            IR_LD: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b01;
                c.ir_write  = 1'b1;
            end
            DECODE: begin
                c.a_write      = 1'b1;
                c.b_write      = 1'b1;
                c.alu_src_b    = 2'b11;
                c.alu_out_load = 1'b1;
            end
            RTYPE: begin
                c.alu_src_a    = 1'b1;
                c.alu_op       = 3'b010;
                c.alu_out_load = 1'b1;
            end
            RT_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.pc_write_cond = 1'b1;
                c.alu_src_a     = 1'b1;
                c.alu_op        = 3'b001;
                c.pc_source     = 2'b01;
                c.branch_ne     = ne;
            end
            MEM_ADDR: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = 2'b10;
                c.alu_out_load = 1'b1;
            end
            LW_WAIT: c.iord = 1'b1;
            LW_WB: begin
                c.iord       = 1'b1;
                c.mem_to_reg = 2'b01;
                c.reg_write  = 1'b1;
            end
            SW_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            SW_WAIT: c.iord = 1'b1;
            LUI: begin
                c.mem_to_reg = 2'b10;
                c.reg_write  = 1'b1;
            end
            J: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            6'h00:        return RTYPE;
            6'h04, 6'h05: return BRANCH;
            6'h23, 6'h2b: return MEM_ADDR;
            6'h0f:        return LUI;
            6'h02:        return J;
`ifdef UC_ILLEGAL_OP_EN
            default:      return ILLEGAL;
`else
            default:      return FETCH;
`endif
        endcase
    endfunction

    assign op_bne = (bus.Op == 6'h05);

    // Wait states leave on wcnt==1, so each one lasts exactly MEM_WAIT cycles
    always_comb begin
        nxt      = state;
        nxt_wcnt = wcnt;
        if (bus.Break) begin
            nxt      = BREAK;
            nxt_wcnt = '0;
        end else begin
            case (state)
                FETCH: begin
                    nxt      = F_WAIT;
                    nxt_wcnt = MW;
                end
                F_WAIT: begin
                    if (wcnt == 4'd1) begin
                        nxt      = IR_LD;
                        nxt_wcnt = '0;
                    end else begin
                        nxt_wcnt = wcnt - 4'd1;
                    end
                end
                IR_LD:  nxt = DECODE;
                DECODE: nxt = dispatch(bus.Op);
                RTYPE:  nxt = RT_WB;
                RT_WB:  nxt = FETCH;
                BRANCH: nxt = FETCH;
                MEM_ADDR: begin
                    if (bus.Op == 6'h23) begin
                        nxt      = LW_WAIT;
                        nxt_wcnt = MW;
                    end else begin
                        nxt = SW_WR;
                    end
                end
                LW_WAIT: begin
                    if (wcnt == 4'd1) begin
                        nxt      = LW_WB;
                        nxt_wcnt = '0;
                    end else begin
                        nxt_wcnt = wcnt - 4'd1;
                    end
                end
                LW_WB: nxt = FETCH;
                SW_WR: begin
                    nxt      = SW_WAIT;
                    nxt_wcnt = MW;
                end
                SW_WAIT: begin
                    if (wcnt == 4'd1) begin
                        nxt      = FETCH;
                        nxt_wcnt = '0;
                    end else begin
                        nxt_wcnt = wcnt - 4'd1;
                    end
                end
                LUI:     nxt = FETCH;
                J:       nxt = FETCH;
                default: ;
            endcase
        end
    end

`ifdef UC_ILLEGAL_OP_EN
    logic illegal_q;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
            wcnt  <= '0;
            ctl   <= dec(FETCH, 1'b0);
`ifdef UC_ILLEGAL_OP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state <= nxt;
            wcnt  <= nxt_wcnt;
            ctl   <= dec(nxt, op_bne);
`ifdef UC_ILLEGAL_OP_EN
            illegal_q <= (nxt == ILLEGAL);
`endif
        end
    end

    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.BranchNE    = ctl.branch_ne;
    assign bus.PCWrite     = ctl.pc_write;
    assign bus.IorD        = ctl.iord;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.AWrite      = ctl.a_write;
    assign bus.BWrite      = ctl.b_write;
    assign bus.ALUOutLoad  = ctl.alu_out_load;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.ALUOp       = ctl.alu_op;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.State_out   = STATE_W'(state);
`ifdef UC_ILLEGAL_OP_EN
    assign bus.IllegalOp   = illegal_q;
`else
    assign bus.IllegalOp   = 1'b0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised scoreboard bench for mc_control_fsm; expected state traces
// come from per-instruction cycle rules, outputs from a per-state table.
module tb_mc_control_fsm;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.STATE_W(6)) bus ();

    mc_control_fsm #(.MEM_WAIT(MW), .STATE_W(6)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcwc, bne, pcw, iord, mw, irw;
        logic       asa, rw, rd, aw, bw, aol;
        logic [1:0] m2r, pcs;
        logic [2:0] aop;
        logic [1:0] asb;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        logic       ne;
    } rec_t;

    rec_t sb[$];
    int   trace[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic ctl_t expect_ctl(input int st, input logic ne);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.asb = 2'b01; c.aol = 1; end
            2:  begin c.pcw = 1; c.pcs = 2'b01; c.irw = 1; end
            3:  begin c.aw = 1; c.bw = 1; c.asb = 2'b11; c.aol = 1; end
            4:  begin c.asa = 1; c.aop = 3'b010; c.aol = 1; end
            5:  begin c.rw = 1; c.rd = 1; end
            6:  begin
                    c.pcwc = 1; c.asa = 1; c.aop = 3'b001;
                    c.pcs = 2'b01; c.bne = ne;
                end
            7:  begin c.asa = 1; c.asb = 2'b10; c.aol = 1; end
            8:  c.iord = 1;
            9:  begin c.iord = 1; c.m2r = 2'b01; c.rw = 1; end
            10: begin c.iord = 1; c.mw = 1; end
            11: c.iord = 1;
            12: begin c.m2r = 2'b10; c.rw = 1; end
            13: begin c.pcw = 1; c.pcs = 2'b10; end
            15: c.ill = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t actual();
        ctl_t a;
        a.pcwc = bus.PCWriteCond; a.bne = bus.BranchNE;
        a.pcw = bus.PCWrite; a.iord = bus.IorD;
        a.mw = bus.MemWrite; a.irw = bus.IRWrite;
        a.asa = bus.ALUSrcA; a.rw = bus.RegWrite;
        a.rd = bus.RegDst; a.aw = bus.AWrite;
        a.bw = bus.BWrite; a.aol = bus.ALUOutLoad;
        a.m2r = bus.MemtoReg; a.pcs = bus.PCSource;
        a.aop = bus.ALUOp; a.asb = bus.ALUSrcB;
        a.ill = bus.IllegalOp;
        return a;
    endfunction

    task automatic compare(input string tag, input int st, input logic ne);
        ctl_t e;
        ctl_t a;
        e = expect_ctl(st, ne);
        a = actual();
        vectors++;
        if (bus.State_out !== 6'(st) || a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: state=%0d outs=%h, required state=%0d outs=%h",
                     tag, $time, bus.State_out, a, st, e);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h0f, 6'h02};
    endfunction

    // Expected state sequence of one instruction, from its cycle count rules
    function automatic void build(input logic [5:0] op);
        trace.delete();
        trace.push_back(0);
        repeat (MW) trace.push_back(1);
        trace.push_back(2);
        trace.push_back(3);
        case (op)
            6'h00: begin trace.push_back(4); trace.push_back(5); end
            6'h04, 6'h05: trace.push_back(6);
            6'h23: begin
                trace.push_back(7);
                repeat (MW) trace.push_back(8);
                trace.push_back(9);
            end
            6'h2b: begin
                trace.push_back(7);
                trace.push_back(10);
                repeat (MW) trace.push_back(11);
            end
            6'h0f: trace.push_back(12);
            6'h02: trace.push_back(13);
            default: begin
`ifdef UC_ILLEGAL_OP_EN
                trace.push_back(15);
`endif
            end
        endcase
    endfunction

    task automatic step(input int st, input logic ne,
                        input logic [5:0] op, input logic brk);
        bus.Op    = (st == 3 || st == 7) ? op : 6'($urandom);
        bus.Break = brk;
        sb.push_back(rec_t'{4'(st), ne});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        bus.Break = 1'b0;
        #1;
        compare(tag, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // kind: 0 plain, 1 Break pulse at index at, 2 async reset at index at
    task automatic run_instr(input logic [5:0] op, input int kind, input int at);
        int idx;
        logic ne;
        build(op);
        ne  = (op == 6'h05);
        idx = (at < 0) ? int'($urandom_range(0, trace.size() - 1)) : at;
        foreach (trace[i]) begin
            if (kind == 2 && i == idx) begin
                do_reset("reset_mid");
                return;
            end
            step(trace[i], ne, op, kind == 1 && i == idx);
            if (kind == 1 && i == idx) begin
                repeat (20) step(14, 1'b0, op, 1'b0);
                do_reset("after_break");
                return;
            end
        end
        if (trace[trace.size() - 1] == 15) begin
            repeat (5) step(15, 1'b0, op, 1'b0);
            step(15, 1'b0, op, 1'b1);
            repeat (3) step(14, 1'b0, op, 1'b0);
            do_reset("after_illegal");
        end
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (!rst && sb.size() > 0) begin
                r = sb.pop_front();
                compare("cycle", int'(r.st), r.ne);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [5:0] op;
        int r;
        bus.Op    = 6'h00;
        bus.Break = 1'b0;
        #1 rst = 1'b1;
        #1 compare("reset", 0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(6'h00, 0, 0);
        run_instr(6'h2b, 0, 0);
        run_instr(6'h23, 2, MW + 4);
        run_instr(6'h05, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h3f, 0, 0);
        run_instr(6'h00, 1, 1);
        run_instr(6'h23, 0, 0);
        run_instr(6'h0f, 0, 0);
        run_instr(6'h02, 0, 0);

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0: op = 6'h00;
                1: op = 6'h04;
                2: op = 6'h05;
                3: op = 6'h23;
                4: op = 6'h2b;
                5: op = 6'h0f;
                6: op = 6'h02;
                default: begin
                    do op = 6'($urandom); while (legal(op));
                end
            endcase
            r = int'($urandom_range(0, 9));
            run_instr(op, (r == 0) ? 1 : (r == 1) ? 2 : 0, -1);
        end

        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d records left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
